vend_change: RTL and testbench

VEND_CHANGE -- requirements
Module: vend_change

---
 rtl/vend_change.sv | 114 +++++++++++
 tb/tb_vend_change.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/vend_change.sv
// rtl/vend_change.sv - coin vending FSM with edge-detected coin input, change return and sales count
module vend_change #(
  parameter int unsigned W     = 8,
  parameter int unsigned PRICE = 3,
  parameter int unsigned VAL_A = 1,
  parameter int unsigned VAL_B = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [1:0]       D_in,
  output logic             D_out_mealy,
  output logic             D_out_moore,
  output logic             Change_out,
  output logic [W-1:0]     Credit,
  output logic             Busy,
  output logic             Reject,
  output logic [CNT_W-1:0] Sales
);

  // Coin values are capped at 2^W: any coin that large overflows the credit anyway,
  // and the cap keeps the W+1 bit sum from wrapping back into the legal range.
  localparam logic [63:0] COIN_CAP = 64'd1 << W;
  localparam logic [W:0]  COIN_A   = (64'(VAL_A) >= COIN_CAP) ? (W+1)'(COIN_CAP) : (W+1)'(VAL_A);
  localparam logic [W:0]  COIN_B   = (64'(VAL_B) >= COIN_CAP) ? (W+1)'(COIN_CAP) : (W+1)'(VAL_B);

  typedef enum logic [1:0] {ACCUM, VEND, CHANGE} state_t;

  state_t     state;
  logic [1:0] d_in_q;
  logic       ev;
  logic       coin_ev;
  logic       cancel_ev;
  logic [W:0] coin_val;
  logic [W:0] sum;
  logic       ovf;
  logic       ge_price;

  assign ev        = (D_in != 2'b00) && (d_in_q == 2'b00);
  assign coin_ev   = ev && (D_in != 2'b11);
  assign cancel_ev = ev && (D_in == 2'b11);
  assign coin_val  = (D_in == 2'b01) ? COIN_A : COIN_B;
  assign sum       = {1'b0, Credit} + coin_val;
  assign ovf       = sum[W];
  assign ge_price  = sum >= (W+1)'(PRICE);

  // Reset_n gates the strobe because d_in_q is held at 00 during reset
  assign D_out_mealy = Reset_n && (state == ACCUM) && coin_ev && !ovf && ge_price;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= ACCUM;
      d_in_q      <= 2'b00;
      Credit      <= '0;
      Sales       <= '0;
      D_out_moore <= 1'b0;
      Change_out  <= 1'b0;
      Reject      <= 1'b0;
      Busy        <= 1'b0;
    end else begin
      d_in_q      <= D_in;
      D_out_moore <= 1'b0;
      Change_out  <= 1'b0;
      Reject      <= 1'b0;
      case (state)
        ACCUM: begin
          if (coin_ev) begin
            if (ovf) begin
              Reject <= 1'b1;
            end else if (ge_price) begin
              Credit      <= sum[W-1:0] - W'(PRICE);
              state       <= VEND;
              D_out_moore <= 1'b1;
              Busy        <= 1'b1;
            end else begin
              Credit <= sum[W-1:0];
            end
          end else if (cancel_ev && (Credit != '0)) begin
            state      <= CHANGE;
            Change_out <= 1'b1;
            Busy       <= 1'b1;
          end
        end
        VEND: begin
          Sales <= Sales + CNT_W'(1);
          if (coin_ev) Reject <= 1'b1;
          if (Credit != '0) begin
            state      <= CHANGE;
            Change_out <= 1'b1;
          end else begin
            state <= ACCUM;
            Busy  <= 1'b0;
          end
        end
        CHANGE: begin
          if (coin_ev) Reject <= 1'b1;
          if (Credit != '0) Credit <= Credit - W'(1);
          // Change_out for the next cycle pays the unit still left after this one
          if (Credit <= W'(1)) begin
            state <= ACCUM;
            Busy  <= 1'b0;
          end else begin
            Change_out <= 1'b1;
          end
        end
        default: begin
          state <= ACCUM;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_change.sv
// tb/tb_vend_change.sv - directed table-driven bench for vend_change
module tb_vend_change;

  logic       clk;
  logic       rst_n;
  logic [1:0] d_in1, d_in2;

  logic       mealy1, moore1, chg1, busy1, rej1;
  logic [7:0] credit1, sales1;
  logic       mealy2, moore2, chg2, busy2, rej2;
  logic [1:0] credit2, sales2;

  int n_chk = 0;
  int n_bad = 0;

  vend_change #(.W(8), .PRICE(3), .VAL_A(1), .VAL_B(2), .CNT_W(8)) dut1 (
    .Clk(clk), .Reset_n(rst_n), .D_in(d_in1),
    .D_out_mealy(mealy1), .D_out_moore(moore1), .Change_out(chg1),
    .Credit(credit1), .Busy(busy1), .Reject(rej1), .Sales(sales1)
  );

  vend_change #(.W(2), .PRICE(3), .VAL_A(1), .VAL_B(2), .CNT_W(2)) dut2 (
    .Clk(clk), .Reset_n(rst_n), .D_in(d_in2),
    .D_out_mealy(mealy2), .D_out_moore(moore2), .Change_out(chg2),
    .Credit(credit2), .Busy(busy2), .Reject(rej2), .Sales(sales2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] d;
    logic       mealy;
    logic       moore;
    logic       chg;
    logic [7:0] credit;
    logic       busy;
    logic       rej;
    logic [7:0] sales;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [1:0] d, input logic m, input logic mo, input logic c,
                     input int cr, input logic b, input logic r, input int s);
    vec_t v;
    v.d = d; v.mealy = m; v.moore = mo; v.chg = c;
    v.credit = 8'(cr); v.busy = b; v.rej = r; v.sales = 8'(s);
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [%0d]: got %0h want %0h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step2(input logic [1:0] d, input int idx, input logic exp_mealy,
                       input int exp_credit, input logic exp_rej, input int exp_sales);
    @(negedge clk);
    d_in2 = d;
    #1;
    chk("w2_mealy", idx, 32'(mealy2), 32'(exp_mealy));
    tick();
    chk("w2_credit", idx, 32'(credit2), 32'(exp_credit));
    chk("w2_reject", idx, 32'(rej2), 32'(exp_rej));
    chk("w2_sales", idx, 32'(sales2), 32'(exp_sales));
  endtask

  initial begin
    rst_n = 1'b0;
    d_in1 = 2'b00;
    d_in2 = 2'b00;

    //  d      mealy moore chg credit busy rej sales
    add(2'b01, 0, 0, 0, 1, 0, 0, 0);
    add(2'b00, 0, 0, 0, 1, 0, 0, 0);
    add(2'b10, 1, 1, 0, 0, 1, 0, 0);
    add(2'b00, 0, 0, 0, 0, 0, 0, 1);
    add(2'b10, 0, 0, 0, 2, 0, 0, 1);
    add(2'b00, 0, 0, 0, 2, 0, 0, 1);
    add(2'b10, 1, 1, 0, 1, 1, 0, 1);
    add(2'b00, 0, 0, 1, 1, 1, 0, 2);
    add(2'b00, 0, 0, 0, 0, 0, 0, 2);
    add(2'b01, 0, 0, 0, 1, 0, 0, 2);
    add(2'b00, 0, 0, 0, 1, 0, 0, 2);
    add(2'b11, 0, 0, 1, 1, 1, 0, 2);
    add(2'b00, 0, 0, 0, 0, 0, 0, 2);
    for (int k = 0; k < 5; k++) add(2'b01, 0, 0, 0, 1, 0, 0, 2);
    add(2'b00, 0, 0, 0, 1, 0, 0, 2);
    add(2'b01, 0, 0, 0, 2, 0, 0, 2);
    add(2'b00, 0, 0, 0, 2, 0, 0, 2);
    add(2'b11, 0, 0, 1, 2, 1, 0, 2);
    add(2'b00, 0, 0, 1, 1, 1, 0, 2);
    add(2'b10, 0, 0, 0, 0, 0, 1, 2);
    add(2'b00, 0, 0, 0, 0, 0, 0, 2);
    add(2'b10, 0, 0, 0, 2, 0, 0, 2);
    add(2'b00, 0, 0, 0, 2, 0, 0, 2);
    add(2'b10, 1, 1, 0, 1, 1, 0, 2);
    add(2'b00, 0, 0, 1, 1, 1, 0, 3);
    add(2'b11, 0, 0, 0, 0, 0, 0, 3);
    add(2'b00, 0, 0, 0, 0, 0, 0, 3);
    add(2'b11, 0, 0, 0, 0, 0, 0, 3);
    add(2'b00, 0, 0, 0, 0, 0, 0, 3);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_credit", 0, 32'(credit1), 32'd0);
    chk("rst_sales", 0, 32'(sales1), 32'd0);
    chk("rst_busy", 0, 32'(busy1), 32'd0);
    chk("rst_moore", 0, 32'(moore1), 32'd0);
    chk("rst_change", 0, 32'(chg1), 32'd0);
    chk("rst_reject", 0, 32'(rej1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      @(negedge clk);
      d_in1 = vq[i].d;
      #1;
      chk("mealy", i, 32'(mealy1), 32'(vq[i].mealy));
      tick();
      chk("moore", i, 32'(moore1), 32'(vq[i].moore));
      chk("change", i, 32'(chg1), 32'(vq[i].chg));
      chk("credit", i, 32'(credit1), 32'(vq[i].credit));
      chk("busy", i, 32'(busy1), 32'(vq[i].busy));
      chk("reject", i, 32'(rej1), 32'(vq[i].rej));
      chk("sales", i, 32'(sales1), 32'(vq[i].sales));
    end

    // W=2: 2 + 2 overflows the credit register
    step2(2'b10, 0, 0, 2, 0, 0);
    step2(2'b00, 1, 0, 2, 0, 0);
    step2(2'b10, 2, 0, 2, 1, 0);
    step2(2'b00, 3, 0, 2, 0, 0);
    step2(2'b11, 4, 0, 2, 0, 0);
    chk("w2_change_start", 4, 32'(chg2), 32'd1);
    step2(2'b00, 5, 0, 1, 0, 0);
    step2(2'b00, 6, 0, 0, 0, 0);
    chk("w2_idle_busy", 6, 32'(busy2), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      step2(2'b10, 10 * k, 0, 2, 0, (k - 1) % 4);
      step2(2'b00, 10 * k + 1, 0, 2, 0, (k - 1) % 4);
      step2(2'b01, 10 * k + 2, 1, 0, 0, (k - 1) % 4);
      step2(2'b00, 10 * k + 3, 0, 0, 0, k % 4);
    end

    // reset asserted between edges while change is being paid out
    @(negedge clk); d_in1 = 2'b01; tick();
    @(negedge clk); d_in1 = 2'b00; tick();
    @(negedge clk); d_in1 = 2'b01; tick();
    @(negedge clk); d_in1 = 2'b00; tick();
    @(negedge clk); d_in1 = 2'b11; tick();
    chk("pre_rst_change", 0, 32'(chg1), 32'd1);
    chk("pre_rst_credit", 0, 32'(credit1), 32'd2);
    #2;
    rst_n = 1'b0;
    d_in1 = 2'b10;
    #1;
    chk("async_credit", 0, 32'(credit1), 32'd0);
    chk("async_change", 0, 32'(chg1), 32'd0);
    chk("async_busy", 0, 32'(busy1), 32'd0);
    chk("async_sales", 0, 32'(sales1), 32'd0);
    chk("async_mealy", 0, 32'(mealy1), 32'd0);
    tick();
    chk("rst_hold_credit", 0, 32'(credit1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_event", 0, 32'(credit1), 32'd2);
    tick();
    chk("post_rst_held", 0, 32'(credit1), 32'd2);
    chk("post_rst_busy", 0, 32'(busy1), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
